// File: rtl/osc_pkg.sv
// Shared constants and helpers for the calibration pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package osc_pkg;

  // Rounding mode encodings for the ROUND parameter.
  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Per-stage control carried alongside the data pipeline.
  typedef struct packed {
    logic vld;
    logic byp;
  } stage_ctl_t;

  // Most negative value representable in a w-bit two's complement word.
  function automatic longint sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Most positive value representable in a w-bit two's complement word.
  function automatic longint sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Gain code meaning x1.0 for a given number of fractional bits.
  function automatic longint unity_gain(input int frac);
    return 64'sd1 <<< frac;
  endfunction

  // Bias added before the fractional shift; zero when truncating.
  function automatic longint round_bias(input int frac, input int rnd);
    if (rnd == ROUND_HALF_UP && frac > 0) begin
      return 64'sd1 <<< (frac - 1);
    end
    return 64'sd0;
  endfunction

endpackage

// File: rtl/osc_calib_ch.sv
// One channel of offset -> gain -> saturate arithmetic (stages S2..S4).
// Latency: 3 enabled cycles from the S1 inputs to y.
// Backpressure: every register advances only when en is high.
module osc_calib_ch
  import osc_pkg::*;
#(
  parameter int DATA_BITS = 16,
  parameter int GAIN_BITS = 16,
  parameter int GAIN_FRAC = 15,
  parameter int ROUND     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic signed [DATA_BITS-1:0] x,
  input  logic signed [DATA_BITS-1:0] off,
  input  logic        [GAIN_BITS-1:0] gain,
  input  logic                        s3_byp,
  output logic signed [DATA_BITS-1:0] y,
  output logic                        clip_nxt
);

  localparam int SW = DATA_BITS + 1;              // offset sum width
  localparam int PW = DATA_BITS + GAIN_BITS + 1;  // product width
  localparam int QW = PW + 1;                     // headroom for rounding bias

  localparam logic signed [SW-1:0] SUM_LO = SW'(sat_lo(DATA_BITS));
  localparam logic signed [SW-1:0] SUM_HI = SW'(sat_hi(DATA_BITS));
  localparam logic signed [QW-1:0] Q_LO   = QW'(sat_lo(DATA_BITS));
  localparam logic signed [QW-1:0] Q_HI   = QW'(sat_hi(DATA_BITS));
  localparam logic signed [QW-1:0] RND    = QW'(round_bias(GAIN_FRAC, ROUND));

  logic signed [SW-1:0]        sum_w;
  logic signed [DATA_BITS-1:0] sum_sat;
  logic                        sum_clip;

  logic signed [DATA_BITS-1:0] s2_sum;
  logic        [GAIN_BITS-1:0] s2_gain;
  logic                        s2_clip;
  logic signed [DATA_BITS-1:0] s2_raw;

  logic signed [PW-1:0]        s3_prod;
  logic                        s3_clip;
  logic signed [DATA_BITS-1:0] s3_raw;

  logic signed [QW-1:0]        q_w;
  logic signed [DATA_BITS-1:0] q_sat;
  logic                        q_clip;

  // S2 input: widen, add offset, clamp back to the sample range.
  always_comb begin
    sum_w    = SW'(x) + SW'(off);
    sum_sat  = DATA_BITS'(sum_w);
    sum_clip = 1'b0;
    if (sum_w > SUM_HI) begin
      sum_sat  = DATA_BITS'(SUM_HI);
      sum_clip = 1'b1;
    end else if (sum_w < SUM_LO) begin
      sum_sat  = DATA_BITS'(SUM_LO);
      sum_clip = 1'b1;
    end
  end

  // S4 input: round, drop fractional bits (floor), clamp to the sample range.
  always_comb begin
    q_w    = (QW'(s3_prod) + RND) >>> GAIN_FRAC;
    q_sat  = DATA_BITS'(q_w);
    q_clip = 1'b0;
    if (q_w > Q_HI) begin
      q_sat  = DATA_BITS'(Q_HI);
      q_clip = 1'b1;
    end else if (q_w < Q_LO) begin
      q_sat  = DATA_BITS'(Q_LO);
      q_clip = 1'b1;
    end
    // Bypassed beats never report clipping.
    clip_nxt = !s3_byp && (s3_clip || q_clip);
  end

  // S2..S4 registers; the raw sample travels alongside for bypass beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_sum  <= '0;
      s2_gain <= '0;
      s2_clip <= 1'b0;
      s2_raw  <= '0;
      s3_prod <= '0;
      s3_clip <= 1'b0;
      s3_raw  <= '0;
      y       <= '0;
    end else if (en) begin
      s2_sum  <= sum_sat;
      s2_gain <= gain;
      s2_clip <= sum_clip;
      s2_raw  <= x;
      // Gain is unsigned: zero-extend it before the signed multiply.
      s3_prod <= PW'(s2_sum) * PW'($signed({1'b0, s2_gain}));
      s3_clip <= s2_clip;
      s3_raw  <= s2_raw;
      y       <= s3_byp ? s3_raw : q_sat;
    end
  end

endmodule

// File: rtl/osc_calib_pipe.sv
// Multi-channel ADC calibration: per-channel offset, gain and saturation with clip reporting.
// Latency: beat accepted on edge N is on m_axis after edge N+3; each stalled cycle adds one.
// Backpressure: whole pipeline freezes while m_axis is stalled; s_axis_tready follows that enable.
module osc_calib_pipe
  import osc_pkg::*;
#(
  parameter int DATA_BITS = 16,
  parameter int NUM_CH    = 2,
  parameter int GAIN_BITS = 16,
  parameter int GAIN_FRAC = 15,
  parameter int ROUND     = 1,
  parameter int CNT_BITS  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH*DATA_BITS-1:0]   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [NUM_CH*DATA_BITS-1:0]   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic [NUM_CH*DATA_BITS-1:0]   cfg_offset,
  input  logic [NUM_CH*GAIN_BITS-1:0]   cfg_gain,
  input  logic                          cfg_load,
  input  logic                          cfg_bypass,
  input  logic                          sat_clr,
  output logic [NUM_CH-1:0]             sat_flag,
  output logic [CNT_BITS-1:0]           sat_cnt
);

  localparam logic [GAIN_BITS-1:0] GAIN_ONE = GAIN_BITS'(unity_gain(GAIN_FRAC));
  localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;

  logic en;

  logic [NUM_CH*DATA_BITS-1:0] off_act;
  logic [NUM_CH*GAIN_BITS-1:0] gain_act;

  stage_ctl_t                  s1_ctl, s2_ctl, s3_ctl;
  logic [NUM_CH*DATA_BITS-1:0] s1_x;
  logic [NUM_CH*DATA_BITS-1:0] s1_off;
  logic [NUM_CH*GAIN_BITS-1:0] s1_gain;

  logic [NUM_CH-1:0] clip_vec;
  logic              s4_load;
  logic              any_clip;

  // A stage may advance when the output register is empty or being drained.
  assign en            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = en;
  assign s4_load       = en && s3_ctl.vld;
  assign any_clip      = |clip_vec;

  // Active configuration; a load overrides the previous values on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      off_act  <= '0;
      gain_act <= {NUM_CH{GAIN_ONE}};
    end else if (cfg_load) begin
      off_act  <= cfg_offset;
      gain_act <= cfg_gain;
    end
  end

  // S1 capture plus valid/bypass pipeline; config is snapshotted with the beat
  // (taking a same-edge cfg_load into account) so each beat is self-consistent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_ctl        <= '0;
      s2_ctl        <= '0;
      s3_ctl        <= '0;
      s1_x          <= '0;
      s1_off        <= '0;
      s1_gain       <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (en) begin
      s1_ctl.vld    <= s_axis_tvalid;
      s1_ctl.byp    <= cfg_bypass;
      s1_x          <= s_axis_tdata;
      s1_off        <= cfg_load ? cfg_offset : off_act;
      s1_gain       <= cfg_load ? cfg_gain : gain_act;
      s2_ctl        <= s1_ctl;
      s3_ctl        <= s2_ctl;
      m_axis_tvalid <= s3_ctl.vld;
    end
  end

  // Per-channel arithmetic lanes; channel 0 sits in the LSBs.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    osc_calib_ch #(
      .DATA_BITS (DATA_BITS),
      .GAIN_BITS (GAIN_BITS),
      .GAIN_FRAC (GAIN_FRAC),
      .ROUND     (ROUND)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .x        (s1_x[c*DATA_BITS +: DATA_BITS]),
      .off      (s1_off[c*DATA_BITS +: DATA_BITS]),
      .gain     (s1_gain[c*GAIN_BITS +: GAIN_BITS]),
      .s3_byp   (s3_ctl.byp),
      .y        (m_axis_tdata[c*DATA_BITS +: DATA_BITS]),
      .clip_nxt (clip_vec[c])
    );
  end

  // Sticky clip flags and saturating clip-beat counter; clear beats a same-edge event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_flag <= '0;
      sat_cnt  <= '0;
    end else if (sat_clr) begin
      sat_flag <= '0;
      sat_cnt  <= '0;
    end else if (s4_load) begin
      sat_flag <= sat_flag | clip_vec;
      if (any_clip && sat_cnt != CNT_MAX) begin
        sat_cnt <= sat_cnt + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_osc_calib_pipe.sv
// Self-checking bench for osc_calib_pipe (rounding and truncating builds side by side).
// Latency: checks the 3-cycle accept-to-output path explicitly.
// Backpressure: random output stalls with scoreboard and hold-stability checks.
module tb_osc_calib_pipe;

  localparam int D  = 16;
  localparam int NC = 2;
  localparam int G  = 16;
  localparam int CB = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC*D-1:0]   s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [NC*D-1:0]   m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [NC*D-1:0]   cfg_offset;
  logic [NC*G-1:0]   cfg_gain;
  logic              cfg_load;
  logic              cfg_bypass;
  logic              sat_clr;
  logic [NC-1:0]     sat_flag;
  logic [CB-1:0]     sat_cnt;

  logic              t_s_tready;
  logic [NC*D-1:0]   t_m_tdata;
  logic              t_m_tvalid;
  logic [NC-1:0]     t_sat_flag;
  logic [CB-1:0]     t_sat_cnt;

  int checks = 0;
  int passed = 0;

  logic [NC*D-1:0] exp_q[$];
  logic [NC*D-1:0] exp_t[$];

  logic            mon_prev_stall = 1'b0;
  logic [NC*D-1:0] mon_prev_dat;
  logic            tmon_prev_stall = 1'b0;
  logic [NC*D-1:0] tmon_prev_dat;

  always #5 clk = ~clk;

  osc_calib_pipe #(.DATA_BITS(D), .NUM_CH(NC), .GAIN_BITS(G), .GAIN_FRAC(15),
                   .ROUND(1), .CNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .cfg_offset(cfg_offset), .cfg_gain(cfg_gain), .cfg_load(cfg_load),
    .cfg_bypass(cfg_bypass), .sat_clr(sat_clr), .sat_flag(sat_flag), .sat_cnt(sat_cnt)
  );

  osc_calib_pipe #(.DATA_BITS(D), .NUM_CH(NC), .GAIN_BITS(G), .GAIN_FRAC(15),
                   .ROUND(0), .CNT_BITS(CB)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(t_s_tready),
    .m_axis_tdata(t_m_tdata), .m_axis_tvalid(t_m_tvalid), .m_axis_tready(m_axis_tready),
    .cfg_offset(cfg_offset), .cfg_gain(cfg_gain), .cfg_load(cfg_load),
    .cfg_bypass(cfg_bypass), .sat_clr(sat_clr), .sat_flag(t_sat_flag), .sat_cnt(t_sat_cnt)
  );

  // Output monitor: ready mirrors enable, held data is stable, beats match the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ({s_axis_tready, t_s_tready} !== {2{!m_axis_tvalid || m_axis_tready}}) begin
        $display("FAIL ready_mirror: tready=%b/%b tvalid=%b m_tready=%b",
                 s_axis_tready, t_s_tready, m_axis_tvalid, m_axis_tready);
      end else passed++;
      if (mon_prev_stall) begin
        checks++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, mon_prev_dat}) begin
          $display("FAIL hold_stable: got v=%b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, mon_prev_dat);
        end else passed++;
      end
      if (tmon_prev_stall) begin
        checks++;
        if ({t_m_tvalid, t_m_tdata} !== {1'b1, tmon_prev_dat}) begin
          $display("FAIL hold_stable_trunc: got v=%b d=%h want v=1 d=%h", t_m_tvalid, t_m_tdata, tmon_prev_dat);
        end else passed++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat_round: unexpected beat %h, none pending", m_axis_tdata);
        end else begin
          logic [NC*D-1:0] e;
          e = exp_q.pop_front();
          if (m_axis_tdata !== e) $display("FAIL beat_round: got %h want %h", m_axis_tdata, e);
          else passed++;
        end
      end
      if (t_m_tvalid && m_axis_tready) begin
        checks++;
        if (exp_t.size() == 0) begin
          $display("FAIL beat_trunc: unexpected beat %h, none pending", t_m_tdata);
        end else begin
          logic [NC*D-1:0] e;
          e = exp_t.pop_front();
          if (t_m_tdata !== e) $display("FAIL beat_trunc: got %h want %h", t_m_tdata, e);
          else passed++;
        end
      end
      mon_prev_stall  = m_axis_tvalid && !m_axis_tready;
      mon_prev_dat    = m_axis_tdata;
      tmon_prev_stall = t_m_tvalid && !m_axis_tready;
      tmon_prev_dat   = t_m_tdata;
    end else begin
      mon_prev_stall  = 1'b0;
      tmon_prev_stall = 1'b0;
    end
  end

  // Advance n edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for acceptance, push expectations for both builds.
  task automatic send_beat(input int x0, input int x1, input int e0, input int e1,
                           input int t0, input int t1, input logic ld);
    int n;
    logic ok;
    s_axis_tdata  = {D'(x1), D'(x0)};
    s_axis_tvalid = 1'b1;
    cfg_load      = ld;
    n  = 0;
    ok = 1'b1;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      n++;
      if (n >= 200) begin
        checks++;
        $display("FAIL accept_timeout: tready stayed %b want 1", s_axis_tready);
        ok = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (ok) begin
      exp_q.push_back({D'(e1), D'(e0)});
      exp_t.push_back({D'(t1), D'(t0)});
    end
    s_axis_tvalid = 1'b0;
    cfg_load      = 1'b0;
  endtask

  // Wait (bounded) until every expected beat has come out.
  task automatic drain(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((exp_q.size() != 0 || exp_t.size() != 0) && n < 100);
    #1;
    checks++;
    if (exp_q.size() != 0 || exp_t.size() != 0)
      $display("FAIL drain_%s: pending %0d/%0d want 0/0", tag, exp_q.size(), exp_t.size());
    else passed++;
  endtask

  task automatic load_cfg(input int o0, input int o1, input int g0, input int g1);
    cfg_offset = {D'(o1), D'(o0)};
    cfg_gain   = {G'(g1), G'(g0)};
    cfg_load   = 1'b1;
    tick(1);
    cfg_load   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    cfg_offset = '0; cfg_gain = '0; cfg_load = 1'b0; cfg_bypass = 1'b0; sat_clr = 1'b0;
    tick(3);
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, sat_flag, sat_cnt} !== '0)
      $display("FAIL reset_state: v=%b d=%h flag=%b cnt=%0d want all 0", m_axis_tvalid, m_axis_tdata, sat_flag, sat_cnt);
    else passed++;
    checks++;
    if ({t_m_tvalid, t_m_tdata, t_sat_flag, t_sat_cnt} !== '0)
      $display("FAIL reset_state_trunc: v=%b d=%h flag=%b cnt=%0d want all 0", t_m_tvalid, t_m_tdata, t_sat_flag, t_sat_cnt);
    else passed++;
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_unity_latency();
    send_beat(1234, -5, 1234, -5, 1234, -5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (m_axis_tvalid !== (i == 3))
        $display("FAIL latency_edge%0d: tvalid=%b want %b", i + 1, m_axis_tvalid, (i == 3));
      else passed++;
    end
    tick(1);
    drain("unity");
    checks++;
    if (sat_flag !== 2'b00) $display("FAIL unity_flag: got %b want 00", sat_flag);
    else passed++;
  endtask

  task automatic test_offset_clip();
    load_cfg(1000, 0, 32'h8000, 32'h8000);
    send_beat(32000, 0, 32767, 0, 32767, 0, 1'b0);
    drain("offset");
    checks++;
    if ({sat_flag, sat_cnt} !== {2'b01, 32'd1})
      $display("FAIL offset_clip_sat: flag=%b cnt=%0d want 01/1", sat_flag, sat_cnt);
    else passed++;
    // Clear lands on the same edge the next clipped beat loads the output stage.
    send_beat(32000, 0, 32767, 0, 32767, 0, 1'b0);
    tick(2);
    sat_clr = 1'b1;
    tick(1);
    sat_clr = 1'b0;
    checks++;
    if ({sat_flag, sat_cnt} !== {2'b00, 32'd0})
      $display("FAIL clr_wins: flag=%b cnt=%0d want 00/0", sat_flag, sat_cnt);
    else passed++;
    drain("clr");
  endtask

  task automatic test_gain();
    load_cfg(0, 0, 32'h8000, 32'hC000);
    send_beat(0, -20000, 0, -30000, 0, -30000, 1'b0);
    drain("gain_ok");
    checks++;
    if (sat_flag !== 2'b00) $display("FAIL gain_noclip_flag: got %b want 00", sat_flag);
    else passed++;
    send_beat(0, -30000, 0, -32768, 0, -32768, 1'b0);
    drain("gain_clip");
    checks++;
    if ({sat_flag, sat_cnt} !== {2'b10, 32'd1})
      $display("FAIL gain_clip_sat: flag=%b cnt=%0d want 10/1", sat_flag, sat_cnt);
    else passed++;
  endtask

  task automatic test_round();
    load_cfg(0, 0, 32'h4000, 32'h4000);
    send_beat(3, -3, 2, -1, 1, -2, 1'b0);
    drain("round");
    checks++;
    if ({sat_flag, sat_cnt} !== {2'b10, 32'd1})
      $display("FAIL round_no_clip: flag=%b cnt=%0d want 10/1", sat_flag, sat_cnt);
    else passed++;
  endtask

  task automatic test_bypass();
    load_cfg(1000, 0, 32'h8000, 32'h8000);
    cfg_bypass = 1'b1;
    send_beat(32000, -7, 32000, -7, 32000, -7, 1'b0);
    cfg_bypass = 1'b0;
    send_beat(32000, -7, 32767, -7, 32767, -7, 1'b0);
    drain("bypass");
    checks++;
    if ({sat_flag, sat_cnt} !== {2'b11, 32'd2})
      $display("FAIL bypass_sat: flag=%b cnt=%0d want 11/2", sat_flag, sat_cnt);
    else passed++;
    load_cfg(0, 0, 32'h8000, 32'h8000);
  endtask

  task automatic test_back_to_back_stall();
    fork
      begin
        for (int k = 0; k < 100; k++) send_beat(k, -k, k, -k, k, -k, 1'b0);
      end
      begin
        repeat (3) begin
          repeat ($urandom_range(8, 25)) @(posedge clk);
          #1 m_axis_tready = 1'b0;
          repeat (5) @(posedge clk);
          #1 m_axis_tready = 1'b1;
        end
      end
    join
    drain("ramp");
  endtask

  task automatic test_cfg_load_reset();
    cfg_offset = {D'(100), D'(100)};
    cfg_gain   = {G'(32'h8000), G'(32'h8000)};
    for (int k = 0; k < 25; k++) begin
      if (k < 10) send_beat(k, -k, k, -k, k, -k, 1'b0);
      else        send_beat(k, -k, k + 100, 100 - k, k + 100, 100 - k, k == 10);
    end
    // Reset with beats still in flight.
    rst_n = 1'b0;
    tick(1);
    checks++;
    if ({m_axis_tvalid, sat_flag, sat_cnt} !== '0)
      $display("FAIL midreset: v=%b flag=%b cnt=%0d want 0/00/0", m_axis_tvalid, sat_flag, sat_cnt);
    else passed++;
    exp_q.delete();
    exp_t.delete();
    rst_n = 1'b1;
    tick(1);
    for (int k = 0; k < 4; k++) send_beat(5 + k, 6 - k, 5 + k, 6 - k, 5 + k, 6 - k, 1'b0);
    drain("restart");
  endtask

  initial begin
    test_reset();
    test_unity_latency();
    test_offset_clip();
    test_gain();
    test_round();
    test_bypass();
    test_back_to_back_stall();
    test_cfg_load_reset();
    tick(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
